// File: rtl/lsu_mmio_stall_if.sv
// Handshaked data-SRAM bus between the load/store unit (master) and the SRAM (slave).
// The master holds req/we/addr/wdata/bmask stable until the slave returns ack with rdata.
interface lsu_mmio_stall_if #(
    parameter int DMEM_AW = 11
) ();
    logic               req;
    logic               we;
    logic [DMEM_AW-1:0] addr;
    logic [31:0]        wdata;
    logic [3:0]         bmask;
    logic [31:0]        rdata;
    logic               ack;

    modport master (output req, we, addr, wdata, bmask, input  rdata, ack);
    modport slave  (input  req, we, addr, wdata, bmask, output rdata, ack);
endinterface

// File: rtl/lsu_mmio_stall.sv
// RV32I load/store unit: external handshaked data SRAM with PC-stall wait states, plus
// zero-wait-state memory-mapped LEDs, 7-seg bank, LCD word and synchronised switches.
module lsu_mmio_stall #(
    parameter int DMEM_AW = 11,
    parameter int NUM_HEX = 8,
    parameter int LEDR_W  = 32,
    parameter int LEDG_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [31:0]          i_addr,
    input  logic [31:0]          i_st_data,
    input  logic                 i_mem_wren,
    input  logic                 i_mem_read,
    input  logic [1:0]           i_size,
    input  logic                 i_ld_un,
    output logic [31:0]          o_ld_data,
    output logic                 o_stall,
    output logic                 o_misalign,
    output logic                 o_bus_err,
    lsu_mmio_stall_if.master     sram,
    output logic [LEDR_W-1:0]    o_io_ledr,
    output logic [LEDG_W-1:0]    o_io_ledg,
    output logic [7*NUM_HEX-1:0] o_io_hex,
    output logic [31:0]          o_io_lcd,
    input  logic [31:0]          i_io_sw
);

    localparam int          HEX_PAGES  = (NUM_HEX + 3) / 4;
    localparam logic [3:0]  LCD_PAGE   = (NUM_HEX > 8) ? 4'(2 + HEX_PAGES) : 4'd4;
    localparam int          CNT_W      = $clog2(TIMEOUT + 1);
    localparam logic [32:0] SRAM_BYTES = 33'd4 << DMEM_AW;
    localparam logic [31:0] LEDR_MASK  = 32'hFFFF_FFFF >> (32 - LEDR_W);
    localparam logic [31:0] LEDG_MASK  = 32'hFFFF_FFFF >> (32 - LEDG_W);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   return 4'b0001 << off;
            2'b01:   return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] d);
        case (size)
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] fmt_load(input logic [31:0] word, input logic [1:0] off,
                                             input logic [1:0] size, input logic un);
        logic [31:0] sh;
        sh = word >> {off, 3'b000};
        case (size)
            2'b00:   return un ? {24'h0, sh[7:0]}   : {{24{sh[7]}}, sh[7:0]};
            2'b01:   return un ? {16'h0, sh[15:0]}  : {{16{sh[15]}}, sh[15:0]};
            default: return sh;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (m[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // Only bits[6:0] of the byte lanes that carry a real digit are kept.
    function automatic logic [31:0] hex_mask(input int page);
        logic [31:0] m;
        m = '0;
        for (int j = 0; j < 4; j++)
            if (4*page + j < NUM_HEX) m[8*j +: 8] = 8'h7F;
        return m;
    endfunction

    state_t               state_q, state_n;
    logic [CNT_W-1:0]     cnt_q;
    logic [DMEM_AW-1:0]   addr_q;
    logic                 we_q;
    logic [31:0]          wdata_q;
    logic [3:0]           bmask_q;
    logic [31:0]          rdata_q;
    logic                 bus_err_q;
    logic [31:0]          ledr_q, ledg_q, lcd_q, sw_meta, sw_sync;
    logic [31:0]          hex_q [HEX_PAGES];

    logic                 request, misaligned, aligned_req, sram_hit, go, timeout_hit;
    logic                 io_word, sel_ledr, sel_ledg, sel_lcd, sel_sw, io_we;
    logic [3:0]           io_pg;
    logic [HEX_PAGES-1:0] sel_hex;
    logic [3:0]           st_mask;
    logic [31:0]          st_data, io_rdata;

    assign request     = i_mem_wren | i_mem_read;
    assign misaligned  = (i_size == 2'b01 && i_addr[0]) || (i_size[1] && i_addr[1:0] != 2'b00);
    assign aligned_req = request & ~misaligned;
    assign o_misalign  = request & misaligned;
    assign sram_hit    = (i_addr[31:16] == 16'h0) && ({1'b0, i_addr} < SRAM_BYTES);
    assign go          = (state_q == IDLE) && aligned_req && sram_hit;
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));
    assign st_mask     = lane_mask(i_size, i_addr[1:0]);
    assign st_data     = lane_data(i_size, i_st_data);

    assign io_word  = (i_addr[31:16] == 16'h1000) && (i_addr[11:2] == 10'h0);
    assign io_pg    = i_addr[15:12];
    assign sel_ledr = io_word && io_pg == 4'd0;
    assign sel_ledg = io_word && io_pg == 4'd1;
    assign sel_lcd  = io_word && io_pg == LCD_PAGE;
    assign sel_sw   = (i_addr[31:2] == 30'h0400_4000);
    assign io_we    = (state_q == IDLE) && aligned_req && i_mem_wren;

    // NOTE: every always_comb output gets a default before any branch, so no path can infer a latch.
    always_comb begin
        sel_hex  = '0;
        io_rdata = '0;
        for (int k = 0; k < HEX_PAGES; k++)
            sel_hex[k] = io_word && io_pg == 4'(2 + k);
        if (sel_ledr) io_rdata = ledr_q;
        if (sel_ledg) io_rdata = ledg_q;
        if (sel_lcd)  io_rdata = lcd_q;
        if (sel_sw)   io_rdata = sw_sync;
        for (int k = 0; k < HEX_PAGES; k++)
            if (sel_hex[k]) io_rdata = hex_q[k];
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_reset) state_q <= IDLE;
        else         state_q <= state_n;
    end

    always_comb begin
        state_n  = state_q;
        o_stall  = 1'b0;
        sram.req = 1'b0;
        case (state_q)
            IDLE: if (go) begin
                o_stall = 1'b1;
                state_n = REQ;
            end
            REQ: begin
                o_stall  = 1'b1;
                sram.req = 1'b1;
                if (sram.ack || timeout_hit) state_n = DONE;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Access parameters are captured once on IDLE->REQ and held for the whole handshake.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_q     <= '0;
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            bmask_q   <= '0;
            rdata_q   <= '0;
            bus_err_q <= 1'b0;
        end else begin
            bus_err_q <= 1'b0;
            if (go) begin
                cnt_q   <= '0;
                addr_q  <= i_addr[DMEM_AW+1:2];
                we_q    <= i_mem_wren;
                wdata_q <= st_data;
                bmask_q <= st_mask;
            end else if (state_q == REQ) begin
                if (sram.ack) begin
                    rdata_q <= sram.rdata;
                end else if (timeout_hit) begin
                    rdata_q   <= '0;
                    bus_err_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    assign sram.we    = we_q;
    assign sram.addr  = addr_q;
    assign sram.wdata = wdata_q;
    assign sram.bmask = bmask_q;
    assign o_bus_err  = bus_err_q;

    always_comb begin
        o_ld_data = '0;
        if (state_q == DONE) begin
            if (!we_q) o_ld_data = fmt_load(rdata_q, i_addr[1:0], i_size, i_ld_un);
        end else if (state_q == IDLE && i_mem_read && !i_mem_wren && !misaligned && !sram_hit) begin
            o_ld_data = fmt_load(io_rdata, i_addr[1:0], i_size, i_ld_un);
        end
    end

    // NOTE: the small HEX register array is reset element by element, unlike a true RAM.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            ledr_q  <= '0;
            ledg_q  <= '0;
            lcd_q   <= '0;
            sw_meta <= '0;
            sw_sync <= '0;
            for (int k = 0; k < HEX_PAGES; k++) hex_q[k] <= '0;
        end else begin
            sw_meta <= i_io_sw;
            sw_sync <= sw_meta;
            if (io_we) begin
                if (sel_ledr) ledr_q <= merge(ledr_q, st_data, st_mask) & LEDR_MASK;
                if (sel_ledg) ledg_q <= merge(ledg_q, st_data, st_mask) & LEDG_MASK;
                if (sel_lcd)  lcd_q  <= merge(lcd_q, st_data, st_mask);
                for (int k = 0; k < HEX_PAGES; k++)
                    if (sel_hex[k]) hex_q[k] <= merge(hex_q[k], st_data, st_mask) & hex_mask(k);
            end
        end
    end

    assign o_io_ledr = ledr_q[LEDR_W-1:0];
    assign o_io_ledg = ledg_q[LEDG_W-1:0];
    assign o_io_lcd  = lcd_q;

    for (genvar i = 0; i < NUM_HEX; i++) begin : g_hex
        assign o_io_hex[7*i +: 7] = hex_q[i/4][8*(i%4) +: 7];
    end

endmodule

// File: tb/tb_lsu_mmio_stall.sv
// Directed bench for lsu_mmio_stall: table of I/O/decode vectors plus hand-written
// SRAM handshake, timeout, switch-latency and mid-access reset sequences.
module tb_lsu_mmio_stall;

    localparam int NUM_HEX = 8;
    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr, st_data, ld_data, io_lcd, io_sw, io_ledr, io_ledg;
    logic        mem_wren, mem_read, ld_un, stall, misalign, bus_err;
    logic [1:0]  size;
    logic [7*NUM_HEX-1:0] io_hex;

    int passed = 0;
    int total  = 0;

    lsu_mmio_stall_if #(.DMEM_AW(11)) sram_bus ();

    lsu_mmio_stall #(
        .DMEM_AW(11), .NUM_HEX(NUM_HEX), .LEDR_W(32), .LEDG_W(32), .TIMEOUT(TIMEOUT)
    ) dut (
        .i_clk(clk), .i_reset(reset), .i_addr(addr), .i_st_data(st_data),
        .i_mem_wren(mem_wren), .i_mem_read(mem_read), .i_size(size), .i_ld_un(ld_un),
        .o_ld_data(ld_data), .o_stall(stall), .o_misalign(misalign), .o_bus_err(bus_err),
        .sram(sram_bus.master), .o_io_ledr(io_ledr), .o_io_ledg(io_ledg), .o_io_hex(io_hex),
        .o_io_lcd(io_lcd), .i_io_sw(io_sw)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else passed++;
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        wren;
        logic        rd;
        logic [1:0]  size;
        logic        un;
        logic        chk_ld;
        logic [31:0] exp_ld;
        logic        exp_mis;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(input logic [31:0] a, input logic [31:0] d, input logic w,
                               input logic r, input logic [1:0] s, input logic u,
                               input logic c, input logic [31:0] e, input logic m);
        vec_t x;
        x.addr = a; x.data = d; x.wren = w; x.rd = r; x.size = s; x.un = u;
        x.chk_ld = c; x.exp_ld = e; x.exp_mis = m;
        return x;
    endfunction

    task automatic sram_op(input logic [31:0] a, input logic [31:0] d, input logic w,
                           input logic r, input logic [1:0] s, input logic u,
                           input int ack_after, input logic [31:0] rdat,
                           output int stalls, output int reqs, output logic [31:0] ld,
                           output logic berr, output logic [3:0] bm, output logic [31:0] wd,
                           output logic [10:0] sa, output logic swe);
        bit done = 0;
        int cyc  = 0;
        stalls = 0; reqs = 0; ld = '0; berr = 1'b0; bm = '0; wd = '0; sa = '0; swe = 1'b0;
        @(negedge clk);
        addr = a; st_data = d; mem_wren = w; mem_read = r; size = s; ld_un = u;
        while (!done && cyc < 60) begin
            #2;
            if (sram_bus.req) begin
                reqs++;
                bm = sram_bus.bmask; wd = sram_bus.wdata; sa = sram_bus.addr; swe = sram_bus.we;
                if (reqs == ack_after + 1) begin
                    sram_bus.ack   = 1'b1;
                    sram_bus.rdata = rdat;
                end
            end
            if (stall) stalls++;
            else begin
                done = 1;
                ld   = ld_data;
                berr = bus_err;
            end
            if (!done) begin
                @(negedge clk);
                sram_bus.ack   = 1'b0;
                sram_bus.rdata = '0;
                cyc++;
            end
        end
        check("sram_op_finished", 64'(done), 64'd1);
        @(posedge clk);
        #1;
        mem_wren = 1'b0; mem_read = 1'b0;
    endtask

    int          n_stall, n_req;
    logic [31:0] r_ld, r_wd;
    logic        r_berr, r_we;
    logic [3:0]  r_bm;
    logic [10:0] r_sa;
    logic [55:0] exp_hex;

    initial begin
        reset = 1'b1; addr = '0; st_data = '0; mem_wren = 1'b0; mem_read = 1'b0;
        size = 2'b10; ld_un = 1'b0; io_sw = 32'h0000_A5F0;
        sram_bus.ack = 1'b0; sram_bus.rdata = '0;

        vecs.push_back(v(32'h1000_0000, 32'h0000_01FF, 1, 0, 2'b00, 0, 0, 32'h0, 0));
        vecs.push_back(v(32'h1000_0000, 32'h0, 0, 1, 2'b10, 0, 1, 32'h0000_00FF, 0));
        vecs.push_back(v(32'h1001_0000, 32'h0, 0, 1, 2'b10, 0, 1, 32'h0000_A5F0, 0));
        vecs.push_back(v(32'h1001_0000, 32'h0, 0, 1, 2'b00, 0, 1, 32'hFFFF_FFF0, 0));
        vecs.push_back(v(32'h1001_0000, 32'h0, 0, 1, 2'b00, 1, 1, 32'h0000_00F0, 0));
        vecs.push_back(v(32'h1001_0000, 32'h0, 0, 1, 2'b01, 0, 1, 32'hFFFF_A5F0, 0));
        vecs.push_back(v(32'h1001_0001, 32'h0, 0, 1, 2'b00, 1, 1, 32'h0000_00A5, 0));
        vecs.push_back(v(32'h1000_1002, 32'h0000_1234, 1, 0, 2'b01, 0, 0, 32'h0, 0));
        vecs.push_back(v(32'h1000_1000, 32'h0, 0, 1, 2'b10, 0, 1, 32'h1234_0000, 0));
        vecs.push_back(v(32'h1000_1002, 32'h0, 0, 1, 2'b01, 0, 1, 32'h0000_1234, 0));
        vecs.push_back(v(32'h1000_2000, 32'hFFFF_FFFF, 1, 0, 2'b10, 0, 0, 32'h0, 0));
        vecs.push_back(v(32'h1000_2000, 32'h0, 0, 1, 2'b10, 0, 1, 32'h7F7F_7F7F, 0));
        vecs.push_back(v(32'h1000_3001, 32'h0000_0006, 1, 0, 2'b00, 0, 0, 32'h0, 0));
        vecs.push_back(v(32'h1000_3000, 32'h0, 0, 1, 2'b10, 0, 1, 32'h0000_0600, 0));
        vecs.push_back(v(32'h1000_4000, 32'hCAFE_F00D, 1, 0, 2'b11, 0, 0, 32'h0, 0));
        vecs.push_back(v(32'h1000_4000, 32'h0, 0, 1, 2'b10, 0, 1, 32'hCAFE_F00D, 0));
        vecs.push_back(v(32'h0000_0002, 32'h0, 0, 1, 2'b10, 0, 1, 32'h0, 1));
        vecs.push_back(v(32'h1000_0001, 32'h0000_FFFF, 1, 0, 2'b01, 0, 1, 32'h0, 1));
        vecs.push_back(v(32'h1000_0003, 32'h0, 0, 1, 2'b01, 0, 1, 32'h0, 1));
        vecs.push_back(v(32'h1000_0000, 32'h0, 0, 1, 2'b10, 0, 1, 32'h0000_00FF, 0));
        vecs.push_back(v(32'h2000_0000, 32'h0000_1111, 1, 0, 2'b10, 0, 0, 32'h0, 0));
        vecs.push_back(v(32'h2000_0000, 32'h0, 0, 1, 2'b10, 0, 1, 32'h0, 0));
        vecs.push_back(v(32'h0000_2000, 32'h0, 0, 1, 2'b10, 0, 1, 32'h0, 0));
        vecs.push_back(v(32'h1000_0000, 32'h0000_0055, 1, 1, 2'b00, 0, 0, 32'h0, 0));
        vecs.push_back(v(32'h1000_0000, 32'h0, 0, 1, 2'b10, 0, 1, 32'h0000_0055, 0));

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #2;
        check("rst_ledr", 64'(io_ledr), 64'h0);
        check("rst_ledg", 64'(io_ledg), 64'h0);
        check("rst_hex", 64'(io_hex), 64'h0);
        check("rst_lcd", 64'(io_lcd), 64'h0);
        check("rst_stall", 64'(stall), 64'h0);
        check("rst_req", 64'(sram_bus.req), 64'h0);
        check("rst_bus_err", 64'(bus_err), 64'h0);
        check("rst_ld_data", 64'(ld_data), 64'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            addr = vecs[i].addr; st_data = vecs[i].data; mem_wren = vecs[i].wren;
            mem_read = vecs[i].rd; size = vecs[i].size; ld_un = vecs[i].un;
            #2;
            if (vecs[i].chk_ld) check($sformatf("vec%0d_ld", i), 64'(ld_data), 64'(vecs[i].exp_ld));
            check($sformatf("vec%0d_misalign", i), 64'(misalign), 64'(vecs[i].exp_mis));
            check($sformatf("vec%0d_stall", i), 64'(stall), 64'h0);
            check($sformatf("vec%0d_req", i), 64'(sram_bus.req), 64'h0);
        end
        @(negedge clk);
        mem_wren = 1'b0; mem_read = 1'b0;
        #2;
        exp_hex = '0;
        for (int i = 0; i < 4; i++) exp_hex[7*i +: 7] = 7'h7F;
        exp_hex[35 +: 7] = 7'h06;
        check("port_ledr", 64'(io_ledr), 64'h0000_0055);
        check("port_ledg", 64'(io_ledg), 64'h1234_0000);
        check("port_hex", 64'(io_hex), 64'(exp_hex));
        check("port_lcd", 64'(io_lcd), 64'hCAFE_F00D);

        // switch synchroniser: old value for two cycles after the input changes
        @(negedge clk);
        io_sw = 32'h1234_5678; addr = 32'h1001_0000; size = 2'b10; ld_un = 1'b0; mem_read = 1'b1;
        #2 check("sw_lat0", 64'(ld_data), 64'h0000_A5F0);
        @(negedge clk);
        #2 check("sw_lat1", 64'(ld_data), 64'h0000_A5F0);
        @(negedge clk);
        #2 check("sw_lat2", 64'(ld_data), 64'h1234_5678);
        mem_read = 1'b0;

        sram_op(32'h0000_0006, 32'h0000_BEEF, 1, 0, 2'b01, 0, 2, 32'h0,
                n_stall, n_req, r_ld, r_berr, r_bm, r_wd, r_sa, r_we);
        check("sh_stall_cycles", 64'(n_stall), 64'd4);
        check("sh_req_cycles", 64'(n_req), 64'd3);
        check("sh_bmask", 64'(r_bm), 64'b1100);
        check("sh_wdata", 64'(r_wd), 64'hBEEF_BEEF);
        check("sh_addr", 64'(r_sa), 64'd1);
        check("sh_we", 64'(r_we), 64'd1);
        check("sh_bus_err", 64'(r_berr), 64'd0);

        sram_op(32'h0000_0006, 32'h0, 0, 1, 2'b01, 0, 0, 32'hBEEF_0000,
                n_stall, n_req, r_ld, r_berr, r_bm, r_wd, r_sa, r_we);
        check("lh_ld", 64'(r_ld), 64'hFFFF_BEEF);
        check("lh_stall_cycles", 64'(n_stall), 64'd2);
        check("lh_we", 64'(r_we), 64'd0);

        sram_op(32'h0000_0006, 32'h0, 0, 1, 2'b01, 1, 0, 32'hBEEF_0000,
                n_stall, n_req, r_ld, r_berr, r_bm, r_wd, r_sa, r_we);
        check("lhu_ld", 64'(r_ld), 64'h0000_BEEF);

        sram_op(32'h0000_0003, 32'h0000_005A, 1, 0, 2'b00, 0, 0, 32'h0,
                n_stall, n_req, r_ld, r_berr, r_bm, r_wd, r_sa, r_we);
        check("sb_bmask", 64'(r_bm), 64'b1000);
        check("sb_wdata", 64'(r_wd), 64'h5A5A_5A5A);

        sram_op(32'h0000_1FFC, 32'h0, 0, 1, 2'b10, 0, 1, 32'h89AB_CDEF,
                n_stall, n_req, r_ld, r_berr, r_bm, r_wd, r_sa, r_we);
        check("lw_top_ld", 64'(r_ld), 64'h89AB_CDEF);
        check("lw_top_stall_cycles", 64'(n_stall), 64'd3);
        check("lw_top_addr", 64'(r_sa), 64'h7FF);

        sram_op(32'h0000_0100, 32'h0, 0, 1, 2'b10, 0, -1, 32'h0,
                n_stall, n_req, r_ld, r_berr, r_bm, r_wd, r_sa, r_we);
        check("to_req_cycles", 64'(n_req), 64'(TIMEOUT));
        check("to_stall_cycles", 64'(n_stall), 64'(TIMEOUT + 1));
        check("to_bus_err", 64'(r_berr), 64'd1);
        check("to_ld", 64'(r_ld), 64'h0);
        @(negedge clk);
        #2;
        check("to_after_stall", 64'(stall), 64'd0);
        check("to_after_bus_err", 64'(bus_err), 64'd0);
        check("to_after_req", 64'(sram_bus.req), 64'd0);

        // reset while the SRAM request is outstanding
        @(negedge clk);
        addr = 32'h0000_0010; size = 2'b10; ld_un = 1'b0; mem_read = 1'b1;
        @(negedge clk);
        #2;
        check("rmid_req_on", 64'(sram_bus.req), 64'd1);
        check("rmid_stall_on", 64'(stall), 64'd1);
        reset = 1'b1; mem_read = 1'b0;
        @(negedge clk);
        #2;
        check("rmid_req_off", 64'(sram_bus.req), 64'd0);
        check("rmid_stall_off", 64'(stall), 64'd0);
        check("rmid_ledr_cleared", 64'(io_ledr), 64'h0);
        reset = 1'b0;

        sram_op(32'h0000_0010, 32'h0, 0, 1, 2'b10, 0, 0, 32'h0BAD_F00D,
                n_stall, n_req, r_ld, r_berr, r_bm, r_wd, r_sa, r_we);
        check("rmid_recover_ld", 64'(r_ld), 64'h0BAD_F00D);
        check("rmid_recover_stall", 64'(n_stall), 64'd2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
